// File: rtl/muldiv_if.sv
// muldiv_if: start/op/operand request and HI/LO/busy/done result bundle between
// control (master) and muldiv_unit (slave).
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, rs_data, rt_data, input busy, done, hi, lo);
  modport slave (input start, op, rs_data, rt_data, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide owning HI/LO; define DIVIDE_EN to build
// the restoring divider, otherwise DIV/DIVU complete as a one-cycle no-op.
module muldiv_unit #(parameter int WIDTH = 32) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               fin_q, neg_q, busy_q, done_q, sgn;
  logic [2*WIDTH-1:0] acc_q, acc_d, res_d;
  logic [WIDTH-1:0]   opnd_q, hi_q, lo_q, abs_rs, abs_rt;
  logic [WIDTH:0]     sum_d;
`ifdef DIVIDE_EN
  logic               div_q, rneg_q;
  logic [WIDTH-1:0]   raw_q, rem_d, quo_d;
  logic [WIDTH:0]     part_d, diff_d;
`endif
  always_comb begin
    sgn = ~bus.op[0];
    abs_rs = (sgn && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    abs_rt = (sgn && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
    sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
`ifdef DIVIDE_EN
    part_d = acc_q[2*WIDTH-1:WIDTH-1];
    diff_d = part_d - {1'b0, opnd_q};
    quo_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    acc_d = !div_q ? {sum_d, acc_q[WIDTH-1:1]} :
            diff_d[WIDTH] ? {part_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0} :
                            {diff_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    // a zero divisor leaves the quotient all ones; HI must carry the raw dividend
    res_d = !div_q ? (neg_q ? -acc_q : acc_q) :
            (opnd_q == '0) ? {raw_q, {WIDTH{1'b1}}} : {rem_d, quo_d};
`else
    acc_d = {sum_d, acc_q[WIDTH-1:1]};
    res_d = neg_q ? -acc_q : acc_q;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      fin_q <= 1'b0;
      neg_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      acc_q <= '0;
      opnd_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
`ifdef DIVIDE_EN
      div_q <= 1'b0;
      rneg_q <= 1'b0;
      raw_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          if (bus.op == 3'b100) hi_q <= bus.rs_data;
          if (bus.op == 3'b101) lo_q <= bus.rs_data;
          if (!bus.op[2]) begin
            cnt_q <= '0;
            fin_q <= 1'b0;
            neg_q <= sgn && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
`ifdef DIVIDE_EN
            state_q <= CALC;
            busy_q <= 1'b1;
            div_q <= bus.op[1];
            rneg_q <= sgn && bus.rs_data[WIDTH-1];
            raw_q <= bus.rs_data;
            opnd_q <= bus.op[1] ? abs_rt : abs_rs;
            acc_q <= {{WIDTH{1'b0}}, bus.op[1] ? abs_rs : abs_rt};
`else
            state_q <= bus.op[1] ? IDLE : CALC;
            busy_q <= ~bus.op[1];
            done_q <= bus.op[1];
            opnd_q <= abs_rs;
            acc_q <= {{WIDTH{1'b0}}, abs_rt};
`endif
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FINISH;
        end
        FINISH: if (!fin_q) begin
          acc_q <= res_d;
          fin_q <= 1'b1;
        end else begin
          {hi_q, lo_q} <= acc_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          fin_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors against muldiv_unit; divide expectations follow DIVIDE_EN.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   lat, bcnt;
  bit   moved, sawdone;
  muldiv_if #(.WIDTH(32)) bus();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int poke);
    logic [31:0] h0, l0;
    h0 = bus.hi;
    l0 = bus.lo;
    moved = 0;
    bus.start = 1'b1;
    bus.op = o;
    bus.rs_data = a;
    bus.rt_data = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    bcnt = int'(bus.busy);
    for (int i = 1; i <= 40 && !bus.done; i++) begin
      if (i == poke) begin
        bus.start = 1'b1;
        bus.op = 3'b001;
        bus.rs_data = 32'd2;
        bus.rt_data = 32'd2;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = i;
      bcnt += int'(bus.busy);
      if (!bus.done && (bus.hi !== h0 || bus.lo !== l0)) moved = 1;
    end
  endtask

  task automatic res(input string t, input int el, input logic [31:0] eh, input logic [31:0] elo);
    chk({t, "_latency"}, 64'(lat), 64'(el));
    chk({t, "_busy_cycles"}, 64'(bcnt), 64'(el));
    chk({t, "_hold"}, 64'(moved), 64'd0);
    chk({t, "_hi"}, 64'(bus.hi), 64'(eh));
    chk({t, "_lo"}, 64'(bus.lo), 64'(elo));
    chk({t, "_busy_at_done"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = 3'b110;
    bus.rs_data = '0;
    bus.rt_data = '0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    res("multu_max", 34, 32'hFFFFFFFE, 32'h00000001);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(bus.done), 64'd0);

    run_op(3'b000, 32'hFFFFFFFD, 32'd5, 0);
    res("mult_neg", 34, 32'hFFFFFFFF, 32'hFFFFFFF1);

    // issued in the same cycle done is high
    run_op(3'b010, 32'hFFFFFFF9, 32'd2, 0);
`ifdef DIVIDE_EN
    res("div_neg", 34, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(3'b011, 32'd100, 32'd0, 0);
    res("divu_zero", 34, 32'd100, 32'hFFFFFFFF);
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 0);
    res("div_ovf", 34, 32'h00000000, 32'h80000000);
`else
    res("div_noop", 0, 32'hFFFFFFFF, 32'hFFFFFFF1);
    chk("div_noop_done", 64'(bus.done), 64'd1);
    run_op(3'b011, 32'd100, 32'd0, 0);
    res("divu_noop", 0, 32'hFFFFFFFF, 32'hFFFFFFF1);
`endif
    @(posedge clk); #1;

    run_op(3'b001, 32'd7, 32'd6, 10);
    res("multu_ignore2", 34, 32'd0, 32'd42);

    bus.start = 1'b1;
    bus.op = 3'b100;
    bus.rs_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("mthi_hi", 64'(bus.hi), 64'hDEADBEEF);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    chk("mthi_done", 64'(bus.done), 64'd0);
    bus.op = 3'b101;
    bus.rs_data = 32'h12345678;
    @(posedge clk); #1;
    chk("mtlo_lo", 64'(bus.lo), 64'h12345678);
    chk("mtlo_hi_kept", 64'(bus.hi), 64'hDEADBEEF);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    chk("mtlo_done", 64'(bus.done), 64'd0);
    bus.op = 3'b110;
    bus.rs_data = 32'h0BADF00D;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("nop_hi", 64'(bus.hi), 64'hDEADBEEF);
    chk("nop_lo", 64'(bus.lo), 64'h12345678);
    chk("nop_busy", 64'(bus.busy), 64'd0);

    bus.start = 1'b1;
    bus.op = 3'b001;
    bus.rs_data = 32'd3;
    bus.rt_data = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("calc_busy", 64'(bus.busy), 64'd1);
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sawdone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) sawdone = 1;
    end
    chk("midrst_no_done", 64'(sawdone), 64'd0);
    chk("midrst_idle", 64'(bus.busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
